// File: rtl/johnson_seq_ctrl.sv
// Command-driven Johnson (twisted-ring) counter sequencer with binary phase decode.
// Optional illegal-code self-correction is enabled by defining JOHNSON_SELF_CORRECT_EN.
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned STEP_W = 8,
    localparam int unsigned PH_W  = $clog2(2 * WIDTH)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [STEP_W-1:0] steps,
    input  logic              dir,
    input  logic              hold,
    input  logic              stop,
    input  logic              sync_clr,
    output logic [WIDTH-1:0]  ring,
    output logic [PH_W-1:0]   phase,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ring_q, ring_d;
    logic [STEP_W-1:0]  rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   ring_fwd, ring_rev;

    assign ring_fwd = {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
    assign ring_rev = {~ring_q[0], ring_q[WIDTH-1:1]};

`ifdef JOHNSON_SELF_CORRECT_EN
    // A legal code has at most one boundary between adjacent bits.
    logic [WIDTH-2:0] bit_edges;
    logic             illegal;
    logic             err_q, err_d;

    assign bit_edges = ring_q[WIDTH-1:1] ^ ring_q[WIDTH-2:0];
    assign illegal   = (bit_edges & (bit_edges - (WIDTH-1)'(1))) != '0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            ring_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef JOHNSON_SELF_CORRECT_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state, ring stepping and command handling.
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
`ifdef JOHNSON_SELF_CORRECT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    if (steps != '0) begin
                        rem_d   = steps;
                        dir_d   = dir;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (sync_clr) begin
                    ring_d = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    ring_d = dir_q ? ring_rev : ring_fwd;
                    rem_d  = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef JOHNSON_SELF_CORRECT_EN
        // Correction replaces the step; an interrupted step is not counted.
        if (illegal) begin
            ring_d = '0;
            err_d  = 1'b1;
            if (state_q == S_RUN && !stop && !hold) begin
                rem_d   = rem_q;
                state_d = S_RUN;
            end
        end
`endif
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Phase decode: ones count on the rising half, mirrored on the falling half.
    always_comb begin
        int unsigned pc;
        pc = 0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pc = pc + 32'(ring_q[i]);
        end
        phase = ring_q[WIDTH-1] ? PH_W'(2 * WIDTH - pc) : PH_W'(pc);
    end

    assign ring = ring_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef JOHNSON_SELF_CORRECT_EN
    assign err  = err_q;
`else
    assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl (WIDTH=4, STEP_W=8).
// Illegal-code correction is exercised only when JOHNSON_SELF_CORRECT_EN is defined.
module tb_johnson_seq_ctrl;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] steps = '0;
    logic       dir = 1'b0;
    logic       hold = 1'b0;
    logic       stop = 1'b0;
    logic       sync_clr = 1'b0;
    logic [3:0] ring;
    logic [2:0] phase;
    logic       busy;
    logic       done;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    johnson_seq_ctrl #(.WIDTH(4), .STEP_W(8)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .steps(steps), .dir(dir),
        .hold(hold), .stop(stop), .sync_clr(sync_clr),
        .ring(ring), .phase(phase), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        n_cmp++; if (ring !== 4'b0000) begin n_bad++; $display("FAIL reset_ring got %b want 0000", ring); end
        n_cmp++; if (phase !== 3'd0) begin n_bad++; $display("FAIL reset_phase got %0d want 0", phase); end
        n_cmp++; if ({busy, done, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, done, err}); end
        tick;
        clr_n = 1'b1;
        tick;
    endtask

    task automatic test_forward;
        logic [3:0] er [8];
        logic [2:0] ep [8];
        er = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        ep = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        start = 1'b1; steps = 8'd8; dir = 1'b0;
        tick;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || ring !== 4'b0000) begin n_bad++; $display("FAIL fwd_accept got busy=%b ring=%b want busy=1 ring=0000", busy, ring); end
        for (int i = 0; i < 8; i++) begin
            tick;
            n_cmp++; if (ring !== er[i] || phase !== ep[i]) begin n_bad++; $display("FAIL fwd_step%0d got %b/%0d want %b/%0d", i, ring, phase, er[i], ep[i]); end
            n_cmp++; if (busy !== (i < 7) || done !== (i == 7) || err !== 1'b0) begin n_bad++; $display("FAIL fwd_flags%0d got busy=%b done=%b err=%b", i, busy, done, err); end
        end
        tick;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL fwd_done_width got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_reverse;
        logic [3:0] er [3];
        logic [2:0] ep [3];
        er = '{4'b1000, 4'b1100, 4'b1110};
        ep = '{3'd7, 3'd6, 3'd5};
        start = 1'b1; steps = 8'd3; dir = 1'b1;
        tick;
        start = 1'b0; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_cmp++; if (ring !== er[i] || phase !== ep[i]) begin n_bad++; $display("FAIL rev_step%0d got %b/%0d want %b/%0d", i, ring, phase, er[i], ep[i]); end
            n_cmp++; if (done !== (i == 2)) begin n_bad++; $display("FAIL rev_done%0d got %b want %b", i, done, (i == 2)); end
        end
        tick;
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rev_done_once got %b want 0", done); end
    endtask

    task automatic test_hold_stop;
        sync_clr = 1'b1;
        tick;
        sync_clr = 1'b0;
        n_cmp++; if (ring !== 4'b0000) begin n_bad++; $display("FAIL hs_clear got %b want 0000", ring); end
        start = 1'b1; steps = 8'd5;
        tick;
        start = 1'b0;
        tick;
        tick;
        n_cmp++; if (ring !== 4'b0011) begin n_bad++; $display("FAIL hs_step2 got %b want 0011", ring); end
        hold = 1'b1;
        tick;
        tick;
        n_cmp++; if (ring !== 4'b0011 || busy !== 1'b1) begin n_bad++; $display("FAIL hs_held got ring=%b busy=%b want 0011 1", ring, busy); end
        stop = 1'b1;
        tick;
        hold = 1'b0; stop = 1'b0;
        n_cmp++; if (ring !== 4'b0011 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL hs_stop got ring=%b busy=%b done=%b want 0011 0 0", ring, busy, done); end
        tick;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hs_no_done got done=%b busy=%b want 0 0", done, busy); end
        start = 1'b1; steps = 8'd0;
        tick;
        start = 1'b0; stop = 1'b1;
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || ring !== 4'b0011) begin n_bad++; $display("FAIL hs_zero_steps got done=%b busy=%b ring=%b want 1 0 0011", done, busy, ring); end
        tick;
        stop = 1'b0;
        n_cmp++; if (done !== 1'b0 || ring !== 4'b0011) begin n_bad++; $display("FAIL hs_zero_after got done=%b ring=%b want 0 0011", done, ring); end
    endtask

    task automatic test_sync_clr;
        start = 1'b1; steps = 8'd1;
        tick;
        start = 1'b0; sync_clr = 1'b1;
        tick;
        sync_clr = 1'b0;
        n_cmp++; if (ring !== 4'b0111 || done !== 1'b1) begin n_bad++; $display("FAIL sc_run_ignores got ring=%b done=%b want 0111 1", ring, done); end
        tick;
        sync_clr = 1'b1;
        tick;
        sync_clr = 1'b0;
        n_cmp++; if (ring !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL sc_idle_clear got ring=%b busy=%b want 0000 0", ring, busy); end
        start = 1'b1; steps = 8'd3;
        tick;
        start = 1'b0;
        tick; tick; tick; tick;
        n_cmp++; if (ring !== 4'b0111 || done !== 1'b0) begin n_bad++; $display("FAIL sc_rebuild got ring=%b done=%b want 0111 0", ring, done); end
        start = 1'b1; steps = 8'd1; sync_clr = 1'b1;
        tick;
        start = 1'b0; sync_clr = 1'b0;
        n_cmp++; if (ring !== 4'b0111 || busy !== 1'b1) begin n_bad++; $display("FAIL sc_start_wins got ring=%b busy=%b want 0111 1", ring, busy); end
        tick;
        n_cmp++; if (ring !== 4'b1111 || done !== 1'b1) begin n_bad++; $display("FAIL sc_start_run got ring=%b done=%b want 1111 1", ring, done); end
        tick;
        start = 1'b1; stop = 1'b1; steps = 8'd2;
        tick;
        start = 1'b0; stop = 1'b0;
        n_cmp++; if (busy !== 1'b0 || ring !== 4'b1111) begin n_bad++; $display("FAIL sc_start_stop got busy=%b ring=%b want 0 1111", busy, ring); end
        tick;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || ring !== 4'b1111) begin n_bad++; $display("FAIL sc_start_stop2 got busy=%b done=%b ring=%b want 0 0 1111", busy, done, ring); end
    endtask

    task automatic test_reset_mid_run;
        start = 1'b1; steps = 8'd4; dir = 1'b0;
        tick;
        start = 1'b0;
        tick;
        tick;
        n_cmp++; if (ring !== 4'b1100 || busy !== 1'b1) begin n_bad++; $display("FAIL mr_pre got ring=%b busy=%b want 1100 1", ring, busy); end
        #2;
        clr_n = 1'b0;
        #1;
        n_cmp++; if (ring !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mr_async got ring=%b busy=%b done=%b want 0000 0 0", ring, busy, done); end
        tick;
        clr_n = 1'b1;
        tick;
        tick;
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || ring !== 4'b0000) begin n_bad++; $display("FAIL mr_after got done=%b busy=%b ring=%b want 0 0 0000", done, busy, ring); end
    endtask

    task automatic test_self_correct;
        start = 1'b1; steps = 8'd3; dir = 1'b0;
        tick;
        start = 1'b0;
        tick;
`ifdef JOHNSON_SELF_CORRECT_EN
        force dut.ring_q = 4'b0101;
        #1;
        release dut.ring_q;
        tick;
        n_cmp++; if (ring !== 4'b0000 || err !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL scx_fix got ring=%b err=%b busy=%b want 0000 1 1", ring, err, busy); end
        tick;
        n_cmp++; if (ring !== 4'b0001 || err !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL scx_resume got ring=%b err=%b done=%b want 0001 0 0", ring, err, done); end
        tick;
        n_cmp++; if (ring !== 4'b0011 || done !== 1'b1) begin n_bad++; $display("FAIL scx_finish got ring=%b done=%b want 0011 1", ring, done); end
`else
        tick;
        tick;
        n_cmp++; if (ring !== 4'b0111 || done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL scx_off got ring=%b done=%b err=%b want 0111 1 0", ring, done, err); end
`endif
        tick;
        n_cmp++; if (err !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL scx_quiet got err=%b done=%b want 0 0", err, done); end
    endtask

    initial begin
        test_reset;
        test_forward;
        test_reverse;
        test_hold_stop;
        test_sync_clr;
        test_reset_mid_run;
        test_self_correct;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
- Controller that owns and sequences a WIDTH-bit twisted-ring (Johnson) counter.
- Accepts step commands: run N steps in a chosen direction, with pause, abort and synchronous clear.
- Decodes the ring into a binary phase index and reports busy/done.
- Sits between a software/FSM command source and phase-driven datapath logic (e.g. multiphase enables).

Parameters:
- WIDTH, 4, ring width in bits; legal 2..16; sequence length 2*WIDTH.
- STEP_W, 8, width of the step-count input.
- PH_W, $clog2(2*WIDTH), phase output width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- start  input  1  command strobe, sampled on clk
- steps  input  STEP_W  number of steps to run, captured with start
- dir  input  1  0 = forward (shift left, ~MSB into LSB); 1 = reverse (shift right, ~LSB into MSB); captured with start
- hold  input  1  pause stepping while high (RUN only)
- stop  input  1  abort current run
- sync_clr  input  1  synchronous ring clear, honoured only in IDLE
- ring  output  WIDTH  Johnson counter state (registered)
- phase  output  PH_W  binary phase index of ring (combinational from ring)
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- err  output  1  illegal-ring flag (see Optional Feature)

Behaviour:
- Reset (clr_n low, async):
  - state=IDLE; ring=0; remaining=0; dir_q=0; done=0; busy=0; err=0.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE).
- IDLE:
  - start=1, stop=0, steps>0: capture remaining=steps, dir_q=dir; go RUN.
  - start=1, stop=0, steps=0: go DONE; ring unchanged.
  - start=1, stop=1: start ignored; stay IDLE.
  - sync_clr=1 and no start accepted: ring<=0.
  - sync_clr=1 together with an accepted start: start wins; clear dropped.
- RUN, each edge (priority stop > hold > step):
  - stop=1: go IDLE; ring holds its value; no done pulse.
  - hold=1: ring and remaining unchanged.
  - Otherwise: ring advances one step per dir_q; remaining decrements. If remaining was 1, go DONE.
  - start and sync_clr are ignored in RUN.
- DONE: lasts exactly one cycle, then IDLE.
  - start and sync_clr are ignored in DONE.
  - stop in DONE has no effect.
- Step rules:
  - Forward: ring <= {ring[W-2:0], ~ring[W-1]}.
  - Reverse: ring <= {~ring[0], ring[W-1:1]}.
  - Wrap-around is natural: forward from phase 2W-1 goes to phase 0; reverse from phase 0 goes to phase 2W-1.
- Latency:
  - start accepted at edge k with steps=N>0: ring changes at edges k+1..k+N (plus one edge per held cycle).
  - done is high for the cycle after edge k+N.
  - Next start is accepted at the earliest in the cycle following done.
- Phase decode (legal codes only):
  - MSB=0: phase = popcount(ring).
  - MSB=1: phase = 2*WIDTH - popcount(ring).
  - Example WIDTH=4: 0000→0, 0111→3, 1111→4, 1000→7.
- Reset mid-run: immediate return to the reset state; no done pulse.

Optional Feature:
- Macro: JOHNSON_SELF_CORRECT_EN.
- Defined:
  - A ring value outside the 2*WIDTH legal codes is detected combinationally.
  - On the next edge, in any state, ring<=0 and err=1 for one cycle. This overrides stepping and sync_clr.
  - In RUN, the step is not counted (remaining unchanged) and the run continues.
- Undefined:
  - No detection logic; err is tied to 0.
  - Illegal codes circulate unchanged through the shift rule; phase is unspecified for illegal codes.

Test Plan:
- Reset with ring forced non-zero, clr_n low mid-cycle → ring=0000, busy=0, done=0 immediately (asynchronously). Repeat during RUN → no done pulse.
- WIDTH=4, start with steps=8, dir=0 → ring 0001,0011,0111,1111,1110,1100,1000,0000; phase 1..7,0; busy for 8 cycles; done one cycle after the 8th step.
- From ring=0000, start with steps=3, dir=1 → ring 1000,1100,1110; phase 7,6,5; done once.
- start with steps=5; hold high for 2 cycles after step 2, stop asserted together with hold in the 3rd cycle → ring frozen at 0011; state IDLE; no done. Then start with steps=0 → done next cycle, ring unchanged.
- In IDLE with ring=0111: sync_clr → ring=0000. sync_clr+start same cycle → start accepted, no clear. start+stop in IDLE → ignored.
- With JOHNSON_SELF_CORRECT_EN, force ring=0101 during a run → next edge ring=0000, err pulses once, remaining unchanged, run completes. Without the macro → err stays 0.
